// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache with its controller FSM.
// Define DCACHE_FLUSH_EN to compile the whole-cache flush (write back dirty lines, invalidate all).
module dcache_ctrl #(
  parameter int INDEX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        flush,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int TAG_W = 13 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    RESP
`ifdef DCACHE_FLUSH_EN
    , FLUSH
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         cnt, cnt_nxt;
  logic [LINES-1:0]   valid, dirty;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [15:0]        data_mem [LINES*4];

  logic [INDEX_W-1:0] req_idx, wb_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         req_word;
  logic               illegal, hit;
  logic               data_we, fill_done, set_dirty;
  logic [INDEX_W+1:0] data_waddr;
  logic [15:0]        data_wdata;

  assign req_word = Addr[2:1];
  assign req_idx  = Addr[2+INDEX_W:3];
  assign req_tag  = Addr[15:3+INDEX_W];
  assign illegal  = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);

`ifdef DCACHE_FLUSH_EN
  logic [INDEX_W-1:0] fidx, fidx_nxt;
  logic               flushing, flushing_nxt, flush_pend, flush_req, line_inv;
  assign flush_req = flush | flush_pend;
  // During a flush the write-back walks the index counter instead of the request address.
  assign wb_idx    = flushing ? fidx : req_idx;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign wb_idx       = req_idx;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    DataOut    = '0;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    err        = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    data_we    = 1'b0;
    data_waddr = {req_idx, req_word};
    data_wdata = DataIn;
    fill_done  = 1'b0;
    set_dirty  = 1'b0;
`ifdef DCACHE_FLUSH_EN
    fidx_nxt     = fidx;
    flushing_nxt = flushing;
    line_inv     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
`ifdef DCACHE_FLUSH_EN
        if (flush_req) begin
          Stall        = 1'b1;
          state_nxt    = FLUSH;
          fidx_nxt     = '0;
          flushing_nxt = 1'b1;
          cnt_nxt      = '0;
        end else
`endif
        if (illegal) begin
          err = 1'b1;
        end else if (Rd | Wr) begin
          if (hit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            if (Rd) DataOut = data_mem[{req_idx, req_word}];
            else begin
              data_we   = 1'b1;
              set_dirty = 1'b1;
            end
          end else begin
            Stall     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = (valid[req_idx] && dirty[req_idx]) ? WB : FILL;
          end
        end
      end
      WB: begin
        Stall     = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {tag_mem[wb_idx], wb_idx, cnt, 1'b0};
        mem_wdata = data_mem[{wb_idx, cnt}];
        if (mem_ack) begin
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) begin
`ifdef DCACHE_FLUSH_EN
            if (flushing) begin
              line_inv = 1'b1;
              fidx_nxt = fidx + INDEX_W'(1);
              if (&fidx) begin
                state_nxt    = IDLE;
                flushing_nxt = 1'b0;
              end else begin
                state_nxt = FLUSH;
              end
            end else
`endif
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        Stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {req_tag, req_idx, cnt, 1'b0};
        if (mem_ack) begin
          data_we    = 1'b1;
          data_waddr = {req_idx, cnt};
          data_wdata = mem_rdata;
          cnt_nxt    = cnt + 2'd1;
          if (cnt == 2'd3) begin
            fill_done = 1'b1;
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        Done      = 1'b1;
        state_nxt = IDLE;
        if (Rd) DataOut = data_mem[{req_idx, req_word}];
        else begin
          data_we   = 1'b1;
          set_dirty = 1'b1;
        end
      end
`ifdef DCACHE_FLUSH_EN
      FLUSH: begin
        Stall = 1'b1;
        if (valid[fidx] && dirty[fidx]) begin
          state_nxt = WB;
          cnt_nxt   = '0;
        end else begin
          line_inv = 1'b1;
          fidx_nxt = fidx + INDEX_W'(1);
          if (&fidx) begin
            state_nxt    = IDLE;
            flushing_nxt = 1'b0;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // Reset forces every output quiet at once, so memory requests drop mid-miss.
    if (!rst) begin
      DataOut   = '0;
      Done      = 1'b0;
      Stall     = 1'b0;
      CacheHit  = 1'b0;
      err       = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
      dirty <= '0;
`ifdef DCACHE_FLUSH_EN
      fidx       <= '0;
      flushing   <= 1'b0;
      flush_pend <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (fill_done) begin
        valid[req_idx] <= 1'b1;
        dirty[req_idx] <= 1'b0;
      end
      if (set_dirty) dirty[req_idx] <= 1'b1;
`ifdef DCACHE_FLUSH_EN
      fidx       <= fidx_nxt;
      flushing   <= flushing_nxt;
      flush_pend <= (state == IDLE) ? 1'b0 : (flush_pend | flush);
      if (line_inv) begin
        valid[fidx] <= 1'b0;
        dirty[fidx] <= 1'b0;
      end
`endif
    end
  end

  // NOTE: data and tag arrays carry no reset; valid bits alone decide whether contents are used.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (fill_done) tag_mem[req_idx] <= req_tag;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized self-checking bench; a line-level cache model and a handshake
// memory predict hit/miss, latency, read data and the exact main-memory transaction stream.
module tb_dcache_ctrl;
  localparam int INDEX_W = 4;
  localparam int LINES   = 1 << INDEX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Rd = 1'b0, Wr = 1'b0, flush = 1'b0;
  logic [15:0] Addr = '0, DataIn = '0;
  logic [15:0] DataOut, mem_addr, mem_wdata;
  logic        Done, Stall, CacheHit, err, mem_rd, mem_wr;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  dcache_ctrl #(.INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn), .flush(flush),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit aborted  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Main memory device with a configurable per-word wait; logs every accepted transfer.
  logic [15:0] mem     [32768];
  logic [15:0] ref_mem [32768];
  logic [32:0] txn_log[$], exp_log[$];
  int          mem_wait = 0;
  int          wait_cnt = 0;
  int          hold_bad = 0;
  bit          waiting  = 1'b0;
  logic [33:0] held;

  always @(negedge clk) begin
    if (mem_rd && mem_wr) hold_bad++;
    if (mem_rd || mem_wr) begin
      if (waiting && ({mem_rd, mem_wr, mem_addr, mem_wdata} != held)) hold_bad++;
      if (wait_cnt == mem_wait) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        waiting  = 1'b0;
        if (mem_wr) begin
          mem[mem_addr[15:1]] = mem_wdata;
          txn_log.push_back({1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem[mem_addr[15:1]];
          txn_log.push_back({1'b0, mem_addr, mem_rdata});
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
        waiting = 1'b1;
        held    = {mem_rd, mem_wr, mem_addr, mem_wdata};
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      waiting  = 1'b0;
    end
  end

  // Reference cache: whole lines, plain arithmetic on addresses.
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int          m_tag   [LINES];
  logic [15:0] m_data  [LINES][4];

  function automatic logic [15:0] line_addr(input int t, input int idx, input int k);
    return 16'((t << (3 + INDEX_W)) + (idx << 3) + (k << 1));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic write_back(input int idx);
    logic [15:0] a;
    for (int k = 0; k < 4; k++) begin
      a = line_addr(m_tag[idx], idx, k);
      ref_mem[a[15:1]] = m_data[idx][k];
      exp_log.push_back({1'b1, a, m_data[idx][k]});
    end
  endtask

  task automatic model_access(input bit is_wr, input logic [15:0] addr, input logic [15:0] wd,
                              output bit exp_hit, output int exp_cyc, output logic [15:0] exp_rd);
    int idx, t, w;
    logic [15:0] a;
    idx = (int'(addr) >> 3) % LINES;
    t   = int'(addr) >> (3 + INDEX_W);
    w   = (int'(addr) >> 1) % 4;
    exp_hit = m_valid[idx] && (m_tag[idx] == t);
    exp_cyc = 0;
    if (!exp_hit) begin
      exp_cyc = 1 + 4 * (mem_wait + 1);
      if (m_valid[idx] && m_dirty[idx]) begin
        write_back(idx);
        exp_cyc += 4 * (mem_wait + 1);
      end
      for (int k = 0; k < 4; k++) begin
        a = line_addr(t, idx, k);
        m_data[idx][k] = ref_mem[a[15:1]];
        exp_log.push_back({1'b0, a, ref_mem[a[15:1]]});
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = t;
    end
    exp_rd = m_data[idx][w];
    if (is_wr) begin
      m_data[idx][w] = wd;
      m_dirty[idx]   = 1'b1;
    end
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_txn_count"}, txn_log.size(), exp_log.size());
    for (int i = 0; i < txn_log.size() && i < exp_log.size(); i++)
      check({tag, "_txn"}, txn_log[i], exp_log[i]);
  endtask

  task automatic access(input bit is_wr, input logic [15:0] addr, input logic [15:0] wd);
    bit          exp_hit, got_done, hit_seen;
    int          exp_cyc, cyc, stall_bad;
    logic [15:0] exp_rd, rd_seen;
    txn_log.delete();
    exp_log.delete();
    hold_bad = 0;
    model_access(is_wr, addr, wd, exp_hit, exp_cyc, exp_rd);
    @(posedge clk); #1;
    Rd = !is_wr; Wr = is_wr; Addr = addr; DataIn = wd;
    cyc = 0; got_done = 1'b0; stall_bad = 0; hit_seen = 1'b0; rd_seen = '0;
    while (!got_done && cyc <= 200) begin
      @(negedge clk);
      if (Done) begin
        got_done = 1'b1;
        hit_seen = CacheHit;
        rd_seen  = DataOut;
        if (Stall) stall_bad++;
      end else begin
        if (!Stall) stall_bad++;
        cyc++;
      end
    end
    check("done_timeout", got_done, 1'b1);
    if (!got_done) aborted = 1'b1;
    check("latency", cyc, exp_cyc);
    check("cache_hit", hit_seen, exp_hit);
    if (!is_wr) check("rdata", rd_seen, exp_rd);
    check("stall", stall_bad, 0);
    check("mem_hold", hold_bad, 0);
    compare_logs("access");
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
  endtask

  task automatic illegal(input bit both, input logic [15:0] addr);
    txn_log.delete();
    @(posedge clk); #1;
    Rd = 1'b1; Wr = both; Addr = both ? {addr[15:1], 1'b0} : {addr[15:1], 1'b1};
    @(negedge clk);
    check("illegal", {err, Done, Stall, mem_rd, mem_wr}, 5'b10000);
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    check("illegal_traffic", txn_log.size(), 0);
  endtask

  task automatic do_flush();
    int n, exp_cyc;
    txn_log.delete();
    exp_log.delete();
    hold_bad = 0;
    mem_wait = 0;
    exp_cyc  = 0;
`ifdef DCACHE_FLUSH_EN
    exp_cyc = 1 + LINES;
    for (int i = 0; i < LINES; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        write_back(i);
        exp_cyc += 4;
      end
    end
    model_reset();
`endif
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    n = Stall ? 1 : 0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    while (Stall && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("flush_cycles", n, exp_cyc);
    check("flush_hold", hold_bad, 0);
    compare_logs("flush");
  endtask

  task automatic reset_mid_fill(input logic [15:0] addr);
    int n;
    txn_log.delete();
    mem_wait = 0;
    @(posedge clk); #1;
    Rd = 1'b1; Wr = 1'b0; Addr = addr;
    n = 0;
    while (txn_log.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fill_started", txn_log.size(), 2);
    @(posedge clk); #2;
    check("fill_pending", mem_rd, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_drop", {mem_rd, mem_wr, Stall}, 3'b000);
    Rd = 1'b0;
    model_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    access(1'b0, addr, '0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 16'(i * 40503 + 12345);
      ref_mem[i] = mem[i];
    end
    mem[8]     = 16'hBEEF;
    ref_mem[8] = 16'hBEEF;
    model_reset();

    // Outputs stay quiet under reset even with a request present.
    Rd = 1'b1; Addr = 16'h0010;
    #3;
    check("reset_outputs",
          {Done, Stall, CacheHit, err, mem_rd, mem_wr, DataOut, mem_addr, mem_wdata}, 54'd0);
    Rd = 1'b0;
    #19 rst = 1'b1;

    access(1'b0, 16'h0010, '0);
    access(1'b0, 16'h0010, '0);
    access(1'b1, 16'h0012, 16'h1234);
    access(1'b0, 16'h0812, '0);
    mem_wait = 3;
    access(1'b0, 16'h0100, '0);
    mem_wait = 0;

    illegal(1'b1, 16'h0812);
    illegal(1'b0, 16'h0003);
    access(1'b0, 16'h0812, '0);

    access(1'b1, 16'h0012, 16'hA5C3);
    access(1'b0, 16'h0028, '0);
    do_flush();
    access(1'b0, 16'h0010, '0);
    access(1'b0, 16'h0028, '0);

    reset_mid_fill(16'h0038);

    for (int i = 0; i < 200 && !aborted; i++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 19);
      a = line_addr($urandom_range(0, 2), $urandom_range(0, LINES - 1), $urandom_range(0, 3));
      if (r == 0) illegal(1'b1, a);
      else if (r == 1) illegal(1'b0, a);
      else begin
        mem_wait = $urandom_range(0, 2);
        access(1'(r % 2), a, 16'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
